// File: rtl/serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_frame_rx : framed LSB-first serial receiver with one-deep     |
// |                   valid/ready output buffer, parity/frame/overrun.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_frame_rx #(
   parameter int N      = 4,
   parameter bit PAR_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sin,
   input  logic         sin_vld,
   output logic [N-1:0] dout,
   output logic         perr,
   output logic         dvalid,
   input  logic         dready,
   output logic         ferr,
   output logic         ovr,
   output logic         busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] c_LAST = CW'(N - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_DATA   = 2'd1;
   localparam logic [1:0] c_PARITY = 2'd2;
   localparam logic [1:0] c_STOP   = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_shreg;
   logic          r_pbit;
   logic [N-1:0]  r_dout;
   logic          r_perr;
   logic          r_dvalid;
   logic          r_ferr;
   logic          r_ovr;
   logic          w_pbad;

   assign w_pbad = PAR_EN ? ((^r_shreg) ^ r_pbit) : 1'b0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= c_IDLE;
         r_cnt    <= '0;
         r_shreg  <= '0;
         r_pbit   <= 1'b0;
         r_dout   <= '0;
         r_perr   <= 1'b0;
         r_dvalid <= 1'b0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         if (r_dvalid && dready)
            r_dvalid <= 1'b0;
         if (sin_vld) begin
            case (r_state)
               c_IDLE: begin
                  if (!sin) begin
                     r_state <= c_DATA;
                     r_cnt   <= '0;
                  end
               end
               c_DATA: begin
                  r_shreg <= {sin, r_shreg[N-1:1]};
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == c_LAST)
                     r_state <= PAR_EN ? c_PARITY : c_STOP;
               end
               c_PARITY: begin
                  r_pbit  <= sin;
                  r_state <= c_STOP;
               end
               c_STOP: begin
                  // a low stop bit ends the frame; it never doubles as a start bit
                  r_state <= c_IDLE;
                  if (sin) begin
                     if (!r_dvalid || dready) begin
                        r_dout   <= r_shreg;
                        r_perr   <= w_pbad;
                        r_dvalid <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                  end else begin
                     r_ferr <= 1'b1;
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   assign dout   = r_dout;
   assign perr   = r_perr;
   assign dvalid = r_dvalid;
   assign ferr   = r_ferr;
   assign ovr    = r_ovr;
   assign busy   = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver. It sits directly downstream of the N-bit right shift register's serial output (SO).
- It consumes a framed serial bitstream, sent LSB first because the right shifter emits q[0] first. Each frame is one start bit, N data bits, an optional even-parity bit and one stop bit.
- It reassembles the data word and presents it on a one-deep valid/ready output buffer. It flags framing errors, parity errors and overruns.

Parameters:
- N, 4, data word width in bits (N >= 2).
- PAR_EN, 1, 1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- sin  input  1  serial data in; driven from the upstream shifter's SO.
- sin_vld  input  1  bit strobe; sin is sampled only on cycles where sin_vld=1.
- dout  output  N  received data word; the first-received bit is at dout[0].
- perr  output  1  parity error qualifier for dout; valid while dvalid=1.
- dvalid  output  1  output buffer holds an unread word.
- dready  input  1  consumer accepts the word on a cycle where dvalid=1 and dready=1.
- ferr  output  1  one-cycle pulse: stop bit was sampled as 0.
- ovr  output  1  one-cycle pulse: a completed word was dropped because the buffer was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: on a rising edge with rst=0, the following apply regardless of any other input, including mid-frame (the partial frame is discarded):
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, perr=0, dvalid=0, ferr=0, ovr=0, busy=0.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on strobe cycles (sin_vld=1); with sin_vld=0 the FSM holds its state.
- IDLE:
  - Strobe with sin=0 (start bit): go to DATA, clear counter.
  - Strobe with sin=1: stay in IDLE.
- DATA:
  - Each strobe updates shreg <= {sin, shreg[N-1:1]} and counter++.
  - On the Nth data strobe: go to PARITY if PAR_EN=1, else go to STOP.
- PARITY: the strobe captures pbit, then go to STOP. The parity error is p_bad = (^shreg) ^ pbit; even parity means the count of ones across data plus parity bit must be even.
- STOP:
  - Strobe with sin=1: frame good; present the word to the output buffer and go to IDLE.
  - Strobe with sin=0: ferr=1 for the following cycle; the word is discarded and the FSM goes to IDLE. A 0 stop bit is not reinterpreted as a new start bit.
- Output buffer:
  - A good frame writes on the cycle after the stop strobe: dout=shreg, perr=p_bad (0 when PAR_EN=0), dvalid=1.
  - Latency from the stop-bit strobe edge to dvalid=1 is one clock.
  - dout and perr are held stable while dvalid=1 and dready=0.
  - A handshake (dvalid=1, dready=1) clears dvalid on the next edge; dout retains its value.
  - Simultaneous handshake and new-word write on the same edge: the new word loads, dvalid stays 1, and ovr is not asserted.
  - Write while dvalid=1 and dready=0: the new word is dropped, the old word and its perr are kept, and ovr=1 for one cycle.
- Parity-errored words are delivered with perr=1; dropping them is the consumer's decision.
- ferr and ovr are single-cycle pulses and are never sticky.
- busy=1 in DATA, PARITY and STOP.
- Back-to-back frames: the start bit may arrive on the strobe immediately after the stop strobe.

Test Plan:
1. Reset with N=4, PAR_EN=1 -> all outputs 0, busy=0. Frame of strobes 0,1,1,0,1,1,1 (start, data LSB-first 1011 giving word 4'hB, parity 1, stop 1) -> dvalid=1 one clock after the stop strobe; dout=4'hB, perr=0; dready=1 clears dvalid.
2. Same frame with parity bit 0 -> dout=4'hB, perr=1, dvalid=1.
3. Frame 4'h5 with stop bit 0 -> ferr pulses exactly one cycle, dvalid stays 0, FSM returns to IDLE. The next valid frame 4'h3 is received correctly.
4. Two good frames 4'hA then 4'h6 with dready=0 throughout -> dout stays 4'hA, ovr pulses once at the second delivery. Repeat with dready=1 on the delivery cycle -> dout=4'h6, no ovr.
5. sin_vld low for 3 cycles between data bits -> same result as contiguous strobes (4'hB). Gaps of sin=1 strobes in IDLE are ignored.
6. rst=0 after 2 data bits of a frame -> next edge busy=0 and all outputs 0. A subsequent full frame 4'h9 is received correctly with no stale bits.
